// File: rtl/dotprod_arbiter.sv
// dotprod_arbiter
//
// Shares one dotprod engine between NREQ requesters using round-robin
// arbitration. A winning requester's operands are latched into registers that
// drive the engine. The arbiter holds eng_start until eng_done, captures the
// result, and returns it to the winner as a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid / req_ready    per-requester request handshake (ready is one-hot or zero)
//   req_a, req_b             packed operands, element i of requester r at [(r*N+i)*IN_WIDTH +: IN_WIDTH]
//   rsp_valid                one-cycle pulse to the granted requester
//   rsp_result               shared result, valid while any rsp_valid bit is high
//   busy                     high whenever the sequencer is not idle
//   grant_id                 current or most recently granted requester
//   eng_start, eng_a, eng_b  engine drive: start level and latched operands
//   eng_done, eng_result     engine completion level and accumulator output
module dotprod_arbiter #(
    parameter int NREQ      = 4,
    parameter int N         = 8,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 64,
    localparam int GW       = $clog2(NREQ),
    localparam int VW       = N * IN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*VW-1:0]        req_a,
    input  logic [NREQ*VW-1:0]        req_b,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [OUT_WIDTH-1:0]      rsp_result,
    output logic                      busy,
    output logic [GW-1:0]             grant_id,
    output logic                      eng_start,
    output logic [VW-1:0]             eng_a,
    output logic [VW-1:0]             eng_b,
    input  logic                      eng_done,
    input  logic [OUT_WIDTH-1:0]      eng_result
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [GW-1:0]         last_grant_reg;
    logic [GW-1:0]         grant_reg;
    logic [VW-1:0]         a_reg, b_reg;
    logic [OUT_WIDTH-1:0]  result_reg;

    logic [GW-1:0]         winner;
    logic [GW-1:0]         cand;
    logic                  found;
    logic                  accept;

    // Per-requester operand slices, so the winner mux uses constant part-selects.
    logic [VW-1:0]         a_slice [NREQ];
    logic [VW-1:0]         b_slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*VW +: VW];
            assign b_slice[gi] = req_b[gi*VW +: VW];
        end
    endgenerate

    // Round-robin search: start one past the last grant and wrap upward, so the
    // last winner has the lowest priority in the next arbitration round.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_reg) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // rst gates the accept so that a request cannot be acknowledged on an edge
    // that the reset will discard.
    assign accept = (state_reg == IDLE) && found && !rst;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_decode
            assign req_ready[gi] = accept && (winner == GW'(gi));
            assign rsp_valid[gi] = (state_reg == RELEASE) && (grant_reg == GW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (found)    state_next = RUN;
            RUN:     if (eng_done) state_next = RELEASE;
            RELEASE:               state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(NREQ - 1);
            grant_reg      <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            result_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && found) begin
                grant_reg <= winner;
                a_reg     <= a_slice[winner];
                b_reg     <= b_slice[winner];
            end
            // Only the first done seen in RUN is captured; done outside RUN is stale.
            if (state_reg == RUN && eng_done) begin
                result_reg <= eng_result;
            end
            if (state_reg == RELEASE) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

    assign rsp_result = result_reg;
    assign busy       = (state_reg != IDLE);
    assign grant_id   = grant_reg;
    assign eng_start  = (state_reg == RUN);
    assign eng_a      = a_reg;
    assign eng_b      = b_reg;

endmodule

// File: tb/tb_dotprod_arbiter.sv
// tb_dotprod_arbiter
//
// Directed bench for dotprod_arbiter. A small behavioural dotprod engine
// (idle -> 8 calc cycles -> done, held while start stays high) is attached to
// the engine ports. Inputs are driven and outputs sampled on the falling edge.
module tb_dotprod_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int IW   = 32;
    localparam int OW   = 64;
    localparam int VW   = N * IW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*VW-1:0]   req_a;
    logic [NREQ*VW-1:0]   req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [OW-1:0]        rsp_result;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 eng_start;
    logic [VW-1:0]        eng_a;
    logic [VW-1:0]        eng_b;
    logic                 eng_done;
    logic [OW-1:0]        eng_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dotprod_arbiter #(
        .NREQ(NREQ), .N(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .busy       (busy),
        .grant_id   (grant_id),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    // ---------------- behavioural engine ----------------
    typedef enum logic [1:0] {E_IDLE, E_CALC, E_DONE} eng_state_t;
    eng_state_t        e_state;
    int                e_idx;
    logic signed [63:0] e_acc;
    logic [31:0]       e_ae, e_be;
    logic signed [63:0] e_ae64, e_be64;

    always_comb begin
        e_ae   = eng_a[e_idx*IW +: IW];
        e_be   = eng_b[e_idx*IW +: IW];
        e_ae64 = {{32{e_ae[31]}}, e_ae};
        e_be64 = {{32{e_be[31]}}, e_be};
    end

    always @(posedge clk) begin
        if (rst) begin
            e_state <= E_IDLE;
            e_idx   <= 0;
            e_acc   <= '0;
        end else begin
            case (e_state)
                E_IDLE: if (eng_start) begin
                    e_state <= E_CALC;
                    e_idx   <= 0;
                    e_acc   <= '0;
                end
                E_CALC: begin
                    e_acc <= e_acc + e_ae64 * e_be64;
                    e_idx <= e_idx + 1;
                    if (e_idx == N - 1) e_state <= E_DONE;
                end
                E_DONE: if (!eng_start) e_state <= E_IDLE;
                default: e_state <= E_IDLE;
            endcase
        end
    end

    assign eng_done   = (e_state == E_DONE);
    assign eng_result = e_acc;

    // ---------------- stimulus helpers ----------------
    task automatic set_elem(input int r, input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[(r*N+i)*IW +: IW] = a;
        req_b[(r*N+i)*IW +: IW] = b;
    endtask

    task automatic set_const(input int r, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N; i++) set_elem(r, i, a, b);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        tests++; if (eng_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b expected 0", eng_start); end
        tests++; if (eng_a !== '0 || eng_b !== '0) begin fails++; $display("FAIL reset_operands: eng_a/eng_b not zero"); end
        tests++; if (rsp_result !== 64'd0) begin fails++; $display("FAIL reset_result: got %h expected 0", rsp_result); end
        tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        $display("[TB] reset: outputs checked");
        req_valid = 4'b0000;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        for (int i = 0; i < N; i++) set_elem(1, i, 32'(i + 1), 32'(i + 1));
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 4'b0000;
            #1;
            if (k == 1) begin
                tests++; if (eng_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b expected 1", eng_start); end
            end
            if (k <= 11) begin
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy T+%0d: got %b expected 1", k, busy); end
            end else begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle T+%0d: got %b expected 0", k, busy); end
            end
            if (k == 11) begin
                tests++; if (rsp_valid !== 4'b0010) begin fails++; $display("FAIL single_rsp_valid: got %b expected 0010", rsp_valid); end
                tests++; if (rsp_result !== 64'd204) begin fails++; $display("FAIL single_result: got %0d expected 204", rsp_result); end
                tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL single_grant: got %0d expected 1", grant_id); end
            end else begin
                tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL single_no_rsp T+%0d: got %b expected 0000", k, rsp_valid); end
            end
        end
        $display("[TB] single: req1 result %0d", rsp_result);
    endtask

    task automatic test_signed;
        set_const(0, 32'hFFFF_FFFF, 32'd2);
        req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL signed_ready: got %b expected 0001", req_ready); end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 4'b0000;
        end
        #1;
        tests++; if (rsp_valid !== 4'b0001) begin fails++; $display("FAIL signed_rsp_valid: got %b expected 0001", rsp_valid); end
        tests++; if (rsp_result !== 64'hFFFF_FFFF_FFFF_FFF0) begin fails++; $display("FAIL signed_result: got %h expected fffffffffffffff0", rsp_result); end
        $display("[TB] signed: req0 result %h", rsp_result);
        @(negedge clk);
    endtask

    task automatic test_contention;
        int            order [5] = '{0, 1, 2, 3, 0};
        logic [63:0]   expv  [5] = '{64'd8, 64'd32, 64'd72, 64'd128, 64'd8};
        for (int r = 0; r < NREQ; r++) set_const(r, 32'(r + 1), 32'(r + 1));
        rst = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            tests++; if (req_ready !== (4'b0001 << order[n])) begin fails++; $display("FAIL contention_ready op%0d: got %b expected grant %0d", n, req_ready, order[n]); end
            repeat (11) @(negedge clk);
            #1;
            tests++; if (rsp_valid !== (4'b0001 << order[n])) begin fails++; $display("FAIL contention_rsp op%0d: got %b expected bit %0d", n, rsp_valid, order[n]); end
            tests++; if (rsp_result !== expv[n] || grant_id !== 2'(order[n])) begin fails++; $display("FAIL contention_result op%0d: got %0d/id %0d expected %0d/id %0d", n, rsp_result, grant_id, expv[n], order[n]); end
            $display("[TB] contention: op%0d grant %0d result %0d", n, grant_id, rsp_result);
        end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fairness;
        int            order [4] = '{0, 2, 0, 2};
        logic [63:0]   expv  [4] = '{64'd8, 64'd72, 64'd8, 64'd72};
        logic          bad = 1'b0;
        set_const(0, 32'd1, 32'd1);
        set_const(2, 32'd3, 32'd3);
        rst = 1'b1;
        req_valid = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            bad = bad | req_ready[1] | req_ready[3];
            tests++; if (req_ready !== (4'b0001 << order[n])) begin fails++; $display("FAIL fair_ready op%0d: got %b expected grant %0d", n, req_ready, order[n]); end
            for (int k = 1; k <= 11; k++) begin
                @(negedge clk);
                #1;
                bad = bad | req_ready[1] | req_ready[3];
            end
            tests++; if (rsp_valid !== (4'b0001 << order[n]) || rsp_result !== expv[n]) begin fails++; $display("FAIL fair_rsp op%0d: got %b/%0d expected grant %0d/%0d", n, rsp_valid, rsp_result, order[n], expv[n]); end
            $display("[TB] fairness: op%0d grant %0d result %0d", n, grant_id, rsp_result);
        end
        req_valid = 4'b0000;
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL fair_starved_ready: got %b expected 0", bad); end
        @(negedge clk);
    endtask

    task automatic test_latching;
        for (int i = 0; i < N; i++) set_elem(3, i, 32'(i + 1), 32'd1);
        req_valid = 4'b1000;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL latch_ready: got %b expected 1000", req_ready); end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 4'b0000;
                set_const(3, 32'd0, 32'd1);
            end
            #1;
            if (k == 2) begin
                tests++; if (eng_a[31:0] !== 32'd1) begin fails++; $display("FAIL latch_eng_a: got %0d expected 1", eng_a[31:0]); end
            end
        end
        tests++; if (rsp_valid !== 4'b1000 || rsp_result !== 64'd36) begin fails++; $display("FAIL latch_result: got %b/%0d expected 1000/36", rsp_valid, rsp_result); end
        $display("[TB] latching: req3 result %0d", rsp_result);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic seen = 1'b0;
        set_const(2, 32'd3, 32'd3);
        req_valid = 4'b0100;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rstmid_ready: got %b expected 0100", req_ready); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 4'b0000;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || eng_start !== 1'b0) begin fails++; $display("FAIL rstmid_state: busy %b start %b expected 0 0", busy, eng_start); end
        tests++; if (eng_a !== '0 || eng_b !== '0 || rsp_result !== 64'd0 || grant_id !== 2'd0) begin fails++; $display("FAIL rstmid_regs: result %0d grant %0d expected 0 0 with zero operands", rsp_result, grant_id); end
        for (int k = 0; k < 12; k++) begin
            seen = seen | (|rsp_valid);
            @(negedge clk);
            #1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_rsp: got %b expected 0", seen); end
        req_valid = 4'b0100;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rstmid_fresh_ready: got %b expected 0100", req_ready); end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 4'b0000;
        end
        #1;
        tests++; if (rsp_valid !== 4'b0100 || rsp_result !== 64'd72) begin fails++; $display("FAIL rstmid_fresh_result: got %b/%0d expected 0100/72", rsp_valid, rsp_result); end
        @(negedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_fresh_idle: got %b expected 0", busy); end
        $display("[TB] reset_mid: fresh result %0d", rsp_result);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        test_reset;
        test_single;
        test_signed;
        test_contention;
        test_fairness;
        test_latching;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dotprod_arbiter.md
# dotprod_arbiter

Round-robin arbiter and sequencer that shares one `dotprod` engine (8-element signed dot product, start/done level handshake) between `NREQ` requesters. It accepts one operand set at a time and latches it into registers that drive the engine. It holds the engine's `start` until `done`, captures the result, and returns it to the winning requester as a one-cycle response pulse. It sits between the bus-side requester ports and a single `dotprod` instance, which shares the same `clk`/`rst`.

## Interface
- `NREQ`, default 4: number of requesters; must be ≥ 2.
- `N`, default 8: vector length; must match the engine.
- `IN_WIDTH`, default 32: operand element width, two's complement.
- `OUT_WIDTH`, default 64: result width.

Ports:
- `clk`  in  1  single clock for all state.
- `rst`  in  1  reset; synchronous, active-high. The engine's `rst` is tied to this same signal.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*N*IN_WIDTH  element i of requester r at `[(r*N+i)*IN_WIDTH +: IN_WIDTH]`.
- `req_b`  in  NREQ*N*IN_WIDTH  same packing as `req_a`.
- `rsp_valid`  out  NREQ  one-cycle result pulse to the granted requester.
- `rsp_result`  out  OUT_WIDTH  result, shared by all requesters; valid while any `rsp_valid` bit is high.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester.
- `eng_start`  out  1  engine start level.
- `eng_a`  out  N*IN_WIDTH  element i at `[i*IN_WIDTH +: IN_WIDTH]`, driving engine `a_i`.
- `eng_b`  out  N*IN_WIDTH  same packing, driving engine `b_i`.
- `eng_done`  in  1  engine done level.
- `eng_result`  in  OUT_WIDTH  engine accumulator output.

## Operation
- FSM has three states: IDLE, RUN, RELEASE.
- **IDLE**
  - If any `req_valid` bit is set, select the winner by round-robin.
  - Priority search starts at `(last_grant+1) mod NREQ` and wraps upward.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - On that clock edge, latch the winner's `req_a`/`req_b` into the `eng_a`/`eng_b` registers and set `grant_id` to the winner.
  - Go to RUN.
  - With no request, stay in IDLE.
- **RUN**
  - `eng_start` = 1.
  - When `eng_done` = 1, register `eng_result` into `rsp_result` and go to RELEASE.
- **RELEASE**
  - `eng_start` = 0; `rsp_valid[grant_id]` = 1 for exactly this cycle.
  - Set `last_grant` ← `grant_id`.
  - Go to IDLE.
- `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Arithmetic is performed by the engine: signed products, modular accumulation in `OUT_WIDTH`. `rsp_result` is passed through without modification.
- Operands are held stable in the `eng_a`/`eng_b` registers from accept until the next accept. Requester inputs after accept have no effect on the result.
- `eng_done` seen in IDLE or RELEASE is ignored.
- `rsp_result` and `grant_id` keep their last values until overwritten.

## Timing
- Reset values (on the clock edge where `rst`=1):
  - state = IDLE; `last_grant` = NREQ-1, so requester 0 has top priority.
  - `grant_id` = 0, `eng_start` = 0, `eng_a` = `eng_b` = 0, `rsp_result` = 0, `rsp_valid` = 0, `busy` = 0.
  - `req_ready` is forced to 0 while `rst` = 1.
- Reset in any state aborts the operation: no `rsp_valid` is produced and the engine resets on the same edge.
- With a conforming engine (idle → 8 CALC cycles → DONE), for accept in cycle T:
  - T+1: RUN, `eng_start` high.
  - T+10: `eng_done` high.
  - T+11: RELEASE, `rsp_valid` high.
  - T+12: IDLE again; the next accept can happen here.
- Throughput is one operation per 12 cycles.
- In general, `rsp_valid` rises exactly one cycle after the first cycle in RUN where `eng_done` = 1.
- Dropping `eng_start` in RELEASE returns the engine to its idle state by T+12, before the next `eng_start` at T+13.
- At most one `rsp_valid` bit and at most one `req_ready` bit are set in any cycle.
- A requester whose `req_valid` stays high waits at most `NREQ-1` operations before it is granted.

## Test plan
- **Single request.** Requester 1 with a = 1..8, b = 1..8; all other requesters idle.
  - Expect `req_ready[1]` in the accept cycle T.
  - Expect `rsp_valid[1]` at T+11 with `rsp_result` = 204 and `grant_id` = 1.
  - Expect `busy` high for T+1..T+11.
- **Signed values.** Requester 0 with all a = 0xFFFFFFFF (-1) and all b = 2.
  - Expect `rsp_result` = 0xFFFFFFFFFFFFFFF0 (-16).
- **Full contention.** All 4 `req_valid` bits held high from reset.
  - Expect grants in the order 0, 1, 2, 3, 0, with accepts 12 cycles apart.
  - Each response carries its own requester's dot product.
- **Fairness.** Requesters 0 and 2 continuously valid.
  - Expect strictly alternating grants 0, 2, 0, 2; requesters 1 and 3 never see `req_ready`.
- **Operand latching.** Requester 3 changes `req_a` to all zeros one cycle after accept.
  - Expect the result computed from the original operands.
- **Reset mid-operation.** Assert `rst` for one cycle during RUN (T+5).
  - Expect no `rsp_valid` and all outputs at their reset values on the next cycle.
  - A fresh request afterwards completes with the correct result in 12 cycles.
